// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // size is funct3[1:0]: 00 byte, 01 half, otherwise word.
   function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   be_for = 4'b0001 << off;
         2'b01:   be_for = 4'b0011 << {off[1], 1'b0};
         default: be_for = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select: moves the addressed byte/half down to bit 0 and extends it.
module load_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            off_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] result_o
);

   logic [DATA_WIDTH-1:0] lane;
   logic signed [7:0]     byte_s;
   logic signed [15:0]    half_s;

   always_comb begin
      lane   = rdata_i >> {off_i, 3'b000};
      byte_s = $signed(lane[7:0]);
      half_s = $signed(lane[15:0]);
      case (funct3_i)
         F3_B:    result_o = DATA_WIDTH'(byte_s);
         F3_H:    result_o = DATA_WIDTH'(half_s);
         F3_BU:   result_o = DATA_WIDTH'(lane[7:0]);
         F3_HU:   result_o = DATA_WIDTH'(lane[15:0]);
         default: result_o = lane;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus transaction per load/store, stalling
// the pipeline until the bus completes and returning extended load data.
module mem_stage_lsu
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ValidM_i,
   input  logic                  MemReadM_i,
   input  logic                  MemWriteM_i,
   input  logic [2:0]            Funct3M_i,
   input  logic [DATA_WIDTH-1:0] ALUResultM_i,
   input  logic [DATA_WIDTH-1:0] WriteDataM_i,
   output logic                  StallM_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [DATA_WIDTH-1:0] ReadDataW_o,
   output logic                  ReadValidW_o,
   output logic                  AccessErrM_o
);

   lsu_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [3:0]            be_q, be_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic                  we_q, we_d;
   logic                  rvalid_q, rvalid_d;
   logic                  err_q, err_d;

   logic                  one_op, f3_legal, aligned, accept, reject;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] load_res;

   load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .rdata_i  (mem_rdata_i),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .result_o (load_res)
   );

   // Decode of the instruction currently presented by the pipeline register.
   always_comb begin
      one_op = MemReadM_i ^ MemWriteM_i;
      case (Funct3M_i)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = ~MemWriteM_i;
         default:          f3_legal = 1'b0;
      endcase
      case (Funct3M_i[1:0])
         2'b01:   aligned = ~ALUResultM_i[0];
         2'b10:   aligned = (ALUResultM_i[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      case (Funct3M_i[1:0])
         2'b00:   lane_wdata = {4{WriteDataM_i[7:0]}};
         2'b01:   lane_wdata = {2{WriteDataM_i[15:0]}};
         default: lane_wdata = WriteDataM_i;
      endcase
      accept = (state_q == IDLE) && ValidM_i && one_op && f3_legal && aligned;
      reject = (state_q == IDLE) && ValidM_i && (MemReadM_i || MemWriteM_i) &&
               !(one_op && f3_legal && aligned);
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      be_d     = be_q;
      f3_d     = f3_q;
      off_d    = off_q;
      we_d     = we_q;
      rvalid_d = 1'b0;
      err_d    = reject;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               addr_d  = {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
               off_d   = ALUResultM_i[1:0];
               be_d    = be_for(Funct3M_i[1:0], ALUResultM_i[1:0]);
               wdata_d = lane_wdata;
               we_d    = MemWriteM_i;
               f3_d    = Funct3M_i;
            end
         end
         BUSY: begin
            if (mem_ready_i) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d  = load_res;
                  rvalid_d = 1'b1;
               end
            end
         end
         // DONE keeps the still-resident instruction from being issued twice.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         be_q     <= '0;
         f3_q     <= '0;
         off_q    <= '0;
         we_q     <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         be_q     <= be_d;
         f3_q     <= f3_d;
         off_q    <= off_d;
         we_q     <= we_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   // The accept cycle stalls combinationally so upstream freezes immediately.
   assign StallM_o     = accept || (state_q == BUSY);
   assign mem_req_o    = (state_q == BUSY);
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_be_o     = be_q;
   assign mem_wdata_o  = wdata_q;
   assign ReadDataW_o  = rdata_q;
   assign ReadValidW_o = rvalid_q;
   assign AccessErrM_o = err_q;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the pipelined RISC-V core. It consumes the address, store data and control that the execute/memory pipeline register delivers each cycle, and runs one data-memory transaction per load or store over a ready-handshaked bus. It stalls the pipeline while the access is outstanding. It delivers aligned, sign- or zero-extended load data toward writeback.

## Interface
- DATA_WIDTH, 32, datapath and bus width; only 32 is supported.
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- ValidM_i  in  1  an instruction occupies the memory stage.
- MemReadM_i  in  1  the instruction is a load.
- MemWriteM_i  in  1  the instruction is a store.
- Funct3M_i  in  3  access size/sign (RV32I encoding).
- ALUResultM_i  in  32  effective byte address.
- WriteDataM_i  in  32  store data (rs2).
- StallM_o  out  1  freeze the stages upstream of, and including, the memory stage.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address; bits [1:0] are always 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-positioned write data.
- mem_ready_i  in  1  bus completes the request this cycle.
- mem_rdata_i  in  32  read word; valid when mem_ready_i=1.
- ReadDataW_o  out  32  extended load result.
- ReadValidW_o  out  1  one-cycle pulse when ReadDataW_o updates.
- AccessErrM_o  out  1  one-cycle pulse for a misaligned, illegal or conflicting access.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, access accepted (ValidM_i, exactly one of read/write, legal Funct3, aligned):
  - latch address, byte enables, write data, load type and we;
  - StallM_o=1, combinational in this cycle;
  - next state BUSY.
- IDLE, error case (misaligned, illegal funct3, or read and write both set, with ValidM_i):
  - no request and no stall;
  - AccessErrM_o pulses on the next cycle.
- BUSY:
  - mem_req_o=1 and StallM_o=1;
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o held stable until mem_ready_i;
  - on mem_ready_i: capture load data if a read, then go to DONE.
- DONE:
  - StallM_o=0, so the pipeline advances past this instruction;
  - ReadValidW_o=1 for loads only;
  - next state IDLE. DONE exists to prevent re-issue of the still-resident instruction.
- Legal Funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW;
  - all other codes are illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Store lanes:
  - SB: byte replicated ×4, be = 4'b0001<<addr[1:0];
  - SH: half replicated ×2, be = 4'b0011<<{addr[1],1'b0};
  - SW: be=4'b1111.
- Loads: be as for stores. The selected lane is shifted to bit 0, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- ValidM_i=0, or neither read nor write: stay in IDLE with no activity.

## Timing
- Reset values: state IDLE; all outputs 0, including ReadDataW_o=0.
- Reset is asynchronous mid-transaction: mem_req_o drops immediately and the latched access is discarded.
- Access latency with N wait cycles (mem_ready_i first high in the (N+1)th BUSY cycle):
  - stall lasts N+2 cycles (IDLE plus N+1 BUSY);
  - DONE follows in the next cycle.
- Zero-wait access: 3 cycles occupancy, 2 cycles stalled.
- ReadDataW_o holds its value until the next completed load.
- mem_ready_i is ignored outside BUSY.
- Inputs are sampled only in IDLE; upstream changes during BUSY/DONE have no effect.

## Structure
- mem_pkg:
  - lsu_state_t (IDLE/BUSY/DONE);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - be_for(size, addr[1:0]) function.
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], funct3 → 32-bit result). It is unit-tested separately.

## Test plan
- SW 0xDEADBEEF to 0x100, ready on first BUSY cycle:
  - mem_addr_o=0x100, be=1111, wdata=0xDEADBEEF;
  - stall for 2 cycles, then DONE;
  - no ReadValidW_o.
- LB from 0x103, rdata=0x80FF_0000, 3 wait cycles:
  - be=1000, stall for 5 cycles;
  - ReadDataW_o=0xFFFFFF80 with a ReadValidW_o pulse.
- LHU from 0x102, rdata=0xBEEF_1234 → ReadDataW_o=0x0000BEEF.
- SH 0x0000ABCD to 0x102 → be=1100, wdata=0xABCDABCD.
- LW from 0x101 → no mem_req_o, no stall, AccessErrM_o pulse next cycle.
- Funct3=011 with MemRead → AccessErrM_o pulse, no request.
- rst_n low during BUSY:
  - mem_req_o and StallM_o drop asynchronously;
  - after release, state is IDLE and a new LW completes normally.
